// File: rtl/bonk_pkg.sv
// Shared definitions for the CNN pixel pipeline.
//   DATA_W  : pixel width in bits
//   pixel_t : signed Q-format pixel
//   smax    : signed maximum of two pixels (ties return the common value)
package bonk_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] pixel_t;

    function automatic pixel_t smax(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_linebuf.sv
// One-row line buffer holding the horizontal maxima of the even row.
// Ports:
//   clk     : clock
//   wr_en   : write strobe
//   wr_idx  : write index (0..DEPTH-1)
//   wr_data : data written at wr_idx
//   rd_idx  : read index (0..DEPTH-1)
//   rd_data : combinational read of entry rd_idx
// Contents are not reset; every entry is written before it is read.
module maxpool_linebuf
    import bonk_pkg::*;
#(
    parameter int DEPTH = 14,
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 max pooling over a row-major raster stream.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   din        : signed input pixel
//   din_valid  : din accepted this edge
//   dout       : pooled pixel, held between outputs
//   dout_valid : one-cycle pulse per pooled pixel
//   frame_done : one-cycle pulse with the last pooled pixel of a frame
module maxpool_2x2
    import bonk_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int DEPTH = IMG_W / 2;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [IDX_W-1:0] idx;
    logic             col_last;
    logic             row_last;
    logic             lb_we;
    logic [DATA_W-1:0] lb_rd;
    pixel_t           h;
    pixel_t           din_px;
    pixel_t           m;
    pixel_t           pooled;

    assign din_px   = din;
    assign idx      = IDX_W'(col >> 1);
    assign col_last = (col == COL_W'(IMG_W - 1));
    assign row_last = (row == ROW_W'(IMG_H - 1));

    // Horizontal max of the current pair, then vertical max against the
    // pair stored from the even row above.
    assign m      = smax(h, din_px);
    assign pooled = smax(m, pixel_t'(lb_rd));

    // Gated by rst_n so a beat coinciding with reset leaves no trace.
    assign lb_we = rst_n && din_valid && col[0] && !row[0];

    maxpool_linebuf #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_linebuf (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_idx  (idx),
        .wr_data (m),
        .rd_idx  (idx),
        .rd_data (lb_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            h          <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
            if (din_valid) begin
                if (!col[0]) begin
                    h <= din_px;
                end else if (row[0]) begin
                    dout       <= pooled;
                    dout_valid <= 1'b1;
                    frame_done <= col_last && row_last;
                end

                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_2x2.sv
// Self-checking bench for maxpool_2x2 with a 4x4 frame.
module tb_maxpool_2x2;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        din_valid;
    logic [15:0] dout;
    logic        dout_valid;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int outs_seen = 0;
    int fd_seen = 0;
    logic [15:0] last_out;

    maxpool_2x2 #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: the pooled value is simply the largest signed pixel of the
    // 2x2 window whose bottom-right corner is (r, c).
    function automatic logic [15:0] win_max(input logic [15:0] px[N], input int r, input int c);
        int best;
        best = -100000;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                int v;
                v = int'($signed(px[(r - dr) * W + (c - dc)]));
                if (v > best) best = v;
            end
        end
        return 16'(best);
    endfunction

    task automatic idle_check(input string tag);
        @(negedge clk);
        din_valid = 1'b0;
        din = 16'($urandom);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 16'(dout_valid), 16'd0);
        check({tag, "_fd"}, 16'(frame_done), 16'd0);
        check({tag, "_hold"}, dout, last_out);
    endtask

    // Sends the first nbeats pixels of px with 'gap' idle cycles after each.
    task automatic send_frame(input logic [15:0] px[N], input int gap, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int r, c;
            r = i / W;
            c = i % W;
            @(negedge clk);
            din = px[i];
            din_valid = 1'b1;
            @(posedge clk);
            #1;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                last_out = win_max(px, r, c);
                check("out_valid", 16'(dout_valid), 16'd1);
                check("out_data", dout, last_out);
                check("out_fd", 16'(frame_done), 16'(i == N - 1));
                if (dout_valid) outs_seen++;
                if (frame_done) fd_seen++;
            end else begin
                check("beat_valid", 16'(dout_valid), 16'd0);
                check("beat_fd", 16'(frame_done), 16'd0);
                check("beat_hold", dout, last_out);
            end
            for (int g = 0; g < gap; g++) idle_check("gap");
        end
    endtask

    task automatic reset_pulse(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            rst_n = 1'b0;
            din_valid = 1'b1;          // must be ignored
            din = 16'($urandom);
            @(posedge clk);
            #1;
            check("rst_dout", dout, 16'd0);
            check("rst_valid", 16'(dout_valid), 16'd0);
            check("rst_fd", 16'(frame_done), 16'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        din_valid = 1'b0;
        last_out = '0;
    endtask

    initial begin
        logic [15:0] fa[N];
        logic [15:0] fb[N];
        logic [15:0] fr[N];
        int o0, f0;

        rst_n = 1'b0;
        din_valid = 1'b0;
        din = '0;
        last_out = '0;
        reset_pulse(2);

        // Idle after reset
        for (int k = 0; k < 8; k++) idle_check("idle");

        // Ramp frame, continuous: outputs 5, 7, 13, 15
        for (int i = 0; i < N; i++) fa[i] = 16'(i);
        o0 = outs_seen; f0 = fd_seen;
        send_frame(fa, 0, N);
        check("ramp_outs", 16'(outs_seen - o0), 16'd4);
        check("ramp_fd", 16'(fd_seen - f0), 16'd1);
        check("ramp_last", last_out, 16'd15);
        idle_check("post_ramp");

        // Same frame with 3-cycle gaps
        send_frame(fa, 3, N);

        // Signed windows: {-5,-2,-9,-3} and {7,7,7,7}, rest random
        for (int i = 0; i < N; i++) fb[i] = 16'($urandom);
        fb[0] = 16'hFFFB; fb[1] = 16'hFFFE; fb[4] = 16'hFFF7; fb[5] = 16'hFFFD;
        fb[2] = 16'd7;    fb[3] = 16'd7;    fb[6] = 16'd7;    fb[7] = 16'd7;
        send_frame(fb, 0, N);

        // Two random frames back-to-back
        o0 = outs_seen; f0 = fd_seen;
        for (int i = 0; i < N; i++) fr[i] = 16'($urandom);
        send_frame(fr, 0, N);
        for (int i = 0; i < N; i++) fr[i] = 16'($urandom);
        send_frame(fr, 0, N);
        check("b2b_outs", 16'(outs_seen - o0), 16'd8);
        check("b2b_fd", 16'(fd_seen - f0), 16'd2);

        // Abort after 6 beats, reset for one cycle, then a full frame
        for (int i = 0; i < N; i++) fr[i] = 16'($urandom);
        send_frame(fr, 0, 6);
        reset_pulse(1);
        idle_check("post_abort");
        o0 = outs_seen; f0 = fd_seen;
        for (int i = 0; i < N; i++) fr[i] = 16'($urandom);
        send_frame(fr, 1, N);
        check("abort_outs", 16'(outs_seen - o0), 16'd4);
        check("abort_fd", 16'(fd_seen - f0), 16'd1);

        // A few random frames with random gaps
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) fr[i] = 16'($urandom);
            send_frame(fr, int'($urandom_range(0, 2)), N);
        end

        for (int k = 0; k < 4; k++) idle_check("tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
